// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts and sign-extends I/S/B/U/J
// immediates, adds pc, and holds results in a 2-entry skid FIFO.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [XLEN-1:0]  pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic [XLEN-1:0]  target,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  tgt;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    logic        is_i, is_s, is_b, is_u, is_j;
    logic [31:0] imm32;
    logic        err_c;
    logic [XLEN-1:0] imm_x;
    ent_t        ent_in;
    ent_t        head, skid;
    logic [1:0]  count;
    logic        acc, drn;

    assign is_i = (ImmSrc == 3'b000);
    assign is_s = (ImmSrc == 3'b001);
    assign is_b = (ImmSrc == 3'b010);
    assign is_u = (ImmSrc == 3'b011);
    assign is_j = (ImmSrc == 3'b100);

    always_comb begin
        imm32 = '0;
        err_c = 1'b0;
        unique case (1'b1)
            is_i: imm32 = {{20{instr[31]}}, instr[31:20]};
            is_s: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            is_b: imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            is_u: imm32 = {instr[31:12], 12'b0};
            is_j: imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            default: err_c = 1'b1;
        endcase
    end

    // Sign-extend the 32-bit immediate to XLEN (no-op when XLEN is 32).
    assign imm_x = XLEN'($signed(imm32));

    assign ent_in.imm = imm_x;
    assign ent_in.tgt = pc + imm_x;
    assign ent_in.tag = in_tag;
    assign ent_in.err = err_c;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    assign ImmOp   = head.imm;
    assign target  = head.tgt;
    assign out_tag = head.tag;
    assign imm_err = head.err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case (count)
                2'd0: begin
                    if (acc) begin
                        head  <= ent_in;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (acc && drn) begin
                        head <= ent_in;
                    end else if (acc) begin
                        skid  <= ent_in;
                        count <= 2'd2;
                    end else if (drn) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (drn) begin
                        head  <= skid;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed format, backpressure,
// streaming, flush and reset steps, plus an XLEN=64 instance.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, flush, out_valid, out_ready, imm_err;
    logic [31:0] instr, pc, ImmOp, target;
    logic [2:0]  ImmSrc;
    logic [4:0]  in_tag, out_tag;

    logic        w_in_valid, w_in_ready, w_out_valid, w_imm_err;
    logic [31:0] w_instr;
    logic [2:0]  w_ImmSrc;
    logic [63:0] w_pc, w_ImmOp, w_target;
    logic [4:0]  w_out_tag;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .ImmSrc(ImmSrc), .pc(pc), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ImmOp(ImmOp), .target(target), .out_tag(out_tag),
        .imm_err(imm_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .instr(w_instr), .ImmSrc(w_ImmSrc), .pc(w_pc), .in_tag(5'd0),
        .flush(1'b0),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .ImmOp(w_ImmOp), .target(w_target), .out_tag(w_out_tag),
        .imm_err(w_imm_err)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [31:0] ins,
                                   input logic [2:0] src,
                                   input logic [31:0] p,
                                   input logic [4:0] t);
        exp_t e;
        logic signed [31:0] v;
        e.err = 1'b0;
        case (src)
            3'd0: v = $signed(ins) >>> 20;
            3'd1: v = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20;
            3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8],
                               1'b0, 19'b0}) >>> 19;
            3'd3: v = {ins[31:12], 12'b0};
            3'd4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21],
                               1'b0, 11'b0}) >>> 11;
            default: begin
                v = 0;
                e.err = 1'b1;
            end
        endcase
        e.imm = v;
        e.tgt = p + v;
        e.tag = t;
        return e;
    endfunction

    // One clock: score the drain/accept decided by current values, then step.
    task automatic cyc();
        exp_t e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {59'd0, out_tag}, 64'h1F);
            end else begin
                e = q.pop_front();
                chk("imm", ImmOp, e.imm);
                chk("target", target, e.tgt);
                chk("tag", out_tag, e.tag);
                chk("err", imm_err, e.err);
            end
        end
        if (in_valid && in_ready && !flush)
            q.push_back(model(instr, ImmSrc, pc, in_tag));
        if (flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] p, input logic [4:0] t);
        in_valid = 1'b1;
        instr    = ins;
        ImmSrc   = src;
        pc       = p;
        in_tag   = t;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) cyc();
        chk("drained", q.size(), 0);
        chk("idle_out_valid", out_valid, 1'b0);
    endtask

    logic [31:0] fi [5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                            32'h123452B7, 32'h001000EF};
    logic [31:0] fm [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                            32'h12345000, 32'h00000800};
    logic [31:0] ft [5] = '{32'h000000FF, 32'h000000FC, 32'h000000F8,
                            32'h12345100, 32'h00000900};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        rst = 1'b0;
        in_valid = 0; instr = 0; ImmSrc = 0; pc = 0; in_tag = 0;
        flush = 0; out_ready = 1;
        w_in_valid = 0; w_instr = 0; w_ImmSrc = 0; w_pc = 0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_imm", ImmOp, 0);
        chk("rst_target", target, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_err", imm_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            drive(fi[i], 3'(i), 32'h100, 5'(i));
            cyc();
            chk("fmt_latency", out_valid, 1'b1);
            chk("fmt_imm", ImmOp, fm[i]);
            chk("fmt_target", target, ft[i]);
        end
        drain_all();

        drive(32'hFFF00093, 3'b101, 32'h2000, 5'd9);
        cyc();
        chk("illegal_err", imm_err, 1'b1);
        chk("illegal_imm", ImmOp, 0);
        chk("illegal_target", target, 32'h2000);
        drain_all();

        out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 32'h10, 5'd1);
        cyc();
        drive(32'h00200093, 3'd0, 32'h20, 5'd2);
        cyc();
        drive(32'h00300093, 3'd0, 32'h30, 5'd3);
        chk("bp_in_ready", in_ready, 1'b0);
        cyc();
        chk("bp_stable_tag", out_tag, 5'd1);
        chk("bp_stable_imm", ImmOp, 32'h1);
        chk("bp_in_ready2", in_ready, 1'b0);
        cyc();
        chk("bp_stable_tag2", out_tag, 5'd1);
        out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = in_valid && in_ready;
            cyc();
        end
        chk("bp_accept", acc, 1'b1);
        drain_all();

        out_ready = 1'b1;
        drive($urandom, 3'd0, $urandom, 5'd0);
        cyc();
        for (int i = 1; i <= 10; i++) begin
            drive($urandom, 3'($urandom_range(0, 5)), $urandom, 5'(i));
            chk("stream_in_ready", in_ready, 1'b1);
            chk("stream_out_valid", out_valid, 1'b1);
            cyc();
        end
        drain_all();

        out_ready = 1'b0;
        drive(32'h00500093, 3'd0, 32'h0, 5'd5);
        cyc();
        drive(32'h00600093, 3'd0, 32'h0, 5'd6);
        cyc();
        drive(32'h00700093, 3'd0, 32'h0, 5'd7);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush2_out_valid", out_valid, 1'b0);
        chk("flush2_in_ready", in_ready, 1'b1);
        drain_all();

        out_ready = 1'b0;
        drive(32'h00800093, 3'd0, 32'h0, 5'd8);
        cyc();
        drive(32'h00900093, 3'd0, 32'h0, 5'd10);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush1_out_valid", out_valid, 1'b0);
        drain_all();

        out_ready = 1'b0;
        drive(32'h00A00093, 3'd0, 32'h0, 5'd11);
        cyc();
        drive(32'h00B00093, 3'd0, 32'h0, 5'd12);
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_imm", ImmOp, 0);
        chk("post_rst_target", target, 0);
        chk("post_rst_tag", out_tag, 0);
        chk("post_rst_err", imm_err, 1'b0);
        drain_all();

        w_in_valid = 1'b1;
        w_instr = 32'hFFF00093; w_ImmSrc = 3'd0; w_pc = 64'h100;
        @(posedge clk);
        #1;
        chk("x64_i_imm", w_ImmOp, 64'hFFFFFFFFFFFFFFFF);
        w_instr = 32'h800002B7; w_ImmSrc = 3'd3;
        @(posedge clk);
        #1;
        chk("x64_u_imm", w_ImmOp, 64'hFFFFFFFF80000000);
        w_instr = 32'h00800093; w_ImmSrc = 3'd0;
        w_pc = 64'hFFFFFFFFFFFFFFFC;
        @(posedge clk);
        #1;
        chk("x64_wrap_target", w_target, 64'h4);
        chk("x64_valid", w_out_valid, 1'b1);
        w_in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined immediate generator for the decode stage of the pipelined RISC-V core; the successor to the single-cycle sign extender. It supports all five immediate formats (I, S, B, U, J), sign-extends to a parametrised XLEN, and computes pc+imm for branch/jump targets. Results are registered behind a 2-entry skid buffer with valid/ready handshakes on both sides, plus a flush for branch mispredicts.

Parameters:
XLEN, 32, width of immediate, PC and target outputs (32 or 64); instruction width fixed at 32
TAG_W, 5, width of opaque sideband tag (e.g. rd) carried alongside each result

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream has instruction
in_ready  output  1  block can accept this cycle
instr  input  32  instruction word from instruction memory
ImmSrc  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal
pc  input  XLEN  PC of instr
in_tag  input  TAG_W  sideband, passed through unchanged
flush  input  1  discard all buffered and incoming entries
out_valid  output  1  ImmOp/target/out_tag/imm_err valid
out_ready  input  1  downstream accepts this cycle
ImmOp  output  XLEN  sign-extended immediate
target  output  XLEN  pc + ImmOp, modulo 2^XLEN
out_tag  output  TAG_W  tag of the presented entry
imm_err  output  1  presented entry had illegal ImmSrc

Behaviour:
- Immediate extraction (combinational on input side), s = instr[31], all sign-extended to XLEN with s:
  I: instr[31:20]; S: {instr[31:25],instr[11:7]}; B: {instr[31],instr[7],instr[30:25],instr[11:8],0};
  U: {instr[31:12],12'b0}, bits above 31 = s; J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  Illegal ImmSrc: ImmOp = 0, target = pc, imm_err = 1.
- target computed before buffering; wraps modulo 2^XLEN, no overflow flag.
- Storage: 2-entry FIFO (head = presented entry, skid = second), each entry {ImmOp,target,tag,err}.
- Transfers: accept when in_valid & in_ready; drain when out_valid & out_ready.
- in_ready = count < 2, derived from registered count only (no combinational path from out_ready).
- out_valid = count != 0. Outputs are driven from the head register; latency is 1 cycle from acceptance to out_valid.
- Simultaneous accept and drain at count 1: head is replaced by the new entry, count stays 1. At count 2, in_ready = 0, so the drain promotes skid to head and count becomes 1.
- Count 0 to 2 requires two accepts with no drains; order is strictly FIFO.
- Payload is stable while out_valid & !out_ready (no change until drained).
- flush (synchronous, highest priority): next count = 0; any same-cycle accept is discarded; any same-cycle drain still counts for downstream. in_ready is unaffected by flush in that cycle.
- Reset (async assert, sync deassert by the top level): count = 0, out_valid = 0, in_ready = 1, ImmOp = 0, target = 0, out_tag = 0, imm_err = 0. Reset mid-stream discards all entries.
- Payload regs of empty slots hold their last value, but the reset values apply after reset.

Test Plan:
- Per format, XLEN=32, pc=0x100, out_ready=1: I 0xFFF00093 -> ImmOp 0xFFFFFFFF, target 0xFF; S 0xFE20AE23 -> 0xFFFFFFFC; B 0xFE000CE3 -> 0xFFFFFFF8, target 0xF8; U 0x123452B7 -> 0x12345000; J 0x001000EF -> 0x00000800, target 0x900. Each appears with out_valid exactly 1 cycle after acceptance.
- XLEN=64, I 0xFFF00093 -> ImmOp 0xFFFFFFFFFFFFFFFF; U 0x800002B7 -> 0xFFFFFFFF80000000; pc 0xFFFFFFFFFFFFFFFC + 8 (I 0x00800093) -> target 0x4 (wrap).
- Backpressure: out_ready=0, present 3 instrs with tags 1,2,3 back-to-back -> tags 1,2 accepted, in_ready=0 on 3rd cycle, payload stable; raise out_ready -> tags 1,2,3 emerge in order, none lost or duplicated.
- Streaming at count 1 with in_valid=out_ready=1 for 10 cycles -> one result per cycle, in_ready stays 1.
- Flush at count 2 with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, flushed and incoming entries never appear.
- ImmSrc=101 -> imm_err=1, ImmOp=0, target=pc. Assert rst low with count=2 -> out_valid=0 immediately (async), all outputs 0 after release.
